// File: rtl/enc_defines.sv
// Shared encoder definitions.
//
// Holds design-wide defaults used by the encoder pipeline blocks.
//   CTU_W_DEF : default width of CTU counts and CTU indices.
package enc_defines;

    localparam int CTU_W_DEF = 12;

endpackage : enc_defines

// File: rtl/rec_rot_ctrl.sv
// rec_rot_ctrl -- sequences a two-stage CTU pipeline around a two-buffer
// reconstruction rotator.
//
// A frame of N CTUs runs N+1 slots. In slot s, stage 0 (reconstruction,
// buffer port 0) works on CTU s while stage 1 (consumer, buffer port 1)
// works on CTU s-1. After both pending stages report done, the buffers are
// rotated and the next slot begins.
//
// Handshake: each stgX_start_o is a one-cycle pulse with stgX_idx_o valid in
// the same cycle; the stage answers later with a one-cycle stgX_done_i pulse.
// A done pulse is only counted in WAIT for a stage that is still pending.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   frame_start_i          one-cycle frame start, honoured only when idle
//   ctu_num_i              number of CTUs, sampled with frame_start_i
//   stg0_start_o/idx_o     start pulse and CTU index for stage 0
//   stg0_done_i            done pulse from stage 0
//   stg1_start_o/idx_o     start pulse and CTU index for stage 1
//   stg1_done_i            done pulse from stage 1
//   rotate_o               one-cycle rotate request to the rotator
//   rot_sel_o              mirror of the rotator's buffer select
//   busy_o                 high whenever a frame is in progress
//   frame_done_o           one-cycle pulse at the end of a frame
module rec_rot_ctrl
    import enc_defines::*;
#(
    parameter int CTU_W = CTU_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             frame_start_i,
    input  logic [CTU_W-1:0] ctu_num_i,
    output logic             stg0_start_o,
    output logic [CTU_W-1:0] stg0_idx_o,
    input  logic             stg0_done_i,
    output logic             stg1_start_o,
    output logic [CTU_W-1:0] stg1_idx_o,
    input  logic             stg1_done_i,
    output logic             rotate_o,
    output logic             rot_sel_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ROT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]     state_q,   state_d;
    // One extra bit so slot can reach N = 2^CTU_W-1 and step past it.
    logic [CTU_W:0] slot_q,    slot_d;
    logic [CTU_W:0] num_q,     num_d;
    logic           pend0_q,   pend0_d;
    logic           pend1_q,   pend1_d;
    logic           rot_sel_q, rot_sel_d;

    logic           stg0_act;
    logic           stg1_act;

    assign stg0_act = (slot_q < num_q);
    assign stg1_act = (slot_q != '0);

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        num_d     = num_q;
        pend0_d   = pend0_q;
        pend1_d   = pend1_q;
        rot_sel_d = rot_sel_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    num_d   = {1'b0, ctu_num_i};
                    slot_d  = '0;
                    state_d = (ctu_num_i == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                pend0_d = stg0_act;
                pend1_d = stg1_act;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                pend0_d = pend0_q & ~stg0_done_i;
                pend1_d = pend1_q & ~stg1_done_i;
                if (!pend0_d && !pend1_d) begin
                    state_d = S_ROT;
                end
            end
            S_ROT: begin
                rot_sel_d = ~rot_sel_q;
                slot_d    = slot_q + 1'b1;
                state_d   = (slot_q == num_q) ? S_DONE : S_START;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            slot_q    <= '0;
            num_q     <= '0;
            pend0_q   <= 1'b0;
            pend1_q   <= 1'b0;
            rot_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            num_q     <= num_d;
            pend0_q   <= pend0_d;
            pend1_q   <= pend1_d;
            rot_sel_q <= rot_sel_d;
        end
    end

    // Outputs are decoded from registered state only; indices are forced
    // to zero outside their start pulse so idle/reset outputs are all 0.
    assign stg0_start_o = (state_q == S_START) && stg0_act;
    assign stg1_start_o = (state_q == S_START) && stg1_act;
    assign stg0_idx_o   = stg0_start_o ? slot_q[CTU_W-1:0] : '0;
    assign stg1_idx_o   = stg1_start_o ? (slot_q[CTU_W-1:0] - 1'b1) : '0;
    assign rotate_o     = (state_q == S_ROT);
    assign rot_sel_o    = rot_sel_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = (state_q == S_DONE);

endmodule : rec_rot_ctrl

// File: tb/tb_rec_rot_ctrl.sv
// Testbench for rec_rot_ctrl (CTU_W = 4).
module tb_rec_rot_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rstn;
    logic         frame_start_i;
    logic [W-1:0] ctu_num_i;
    logic         stg0_start_o;
    logic [W-1:0] stg0_idx_o;
    logic         stg0_done_i;
    logic         stg1_start_o;
    logic [W-1:0] stg1_idx_o;
    logic         stg1_done_i;
    logic         rotate_o;
    logic         rot_sel_o;
    logic         busy_o;
    logic         frame_done_o;

    rec_rot_ctrl #(.CTU_W(W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .frame_start_i(frame_start_i),
        .ctu_num_i    (ctu_num_i),
        .stg0_start_o (stg0_start_o),
        .stg0_idx_o   (stg0_idx_o),
        .stg0_done_i  (stg0_done_i),
        .stg1_start_o (stg1_start_o),
        .stg1_idx_o   (stg1_idx_o),
        .stg1_done_i  (stg1_done_i),
        .rotate_o     (rotate_o),
        .rot_sel_o    (rot_sel_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    int s0_cnt, s1_cnt, rot_cnt, fd_cnt;
    int last_done, last_rot, fd_cyc, fs_cyc;
    bit have_rot;
    int d0_lat = 1;
    int d1_lat = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- stage responders ----------------
    // Each stage answers with a one-cycle done d cycles after its start.
    initial begin
        int cnt0, cnt1;
        cnt0 = 0;
        cnt1 = 0;
        stg0_done_i = 1'b0;
        stg1_done_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            stg0_done_i = 1'b0;
            stg1_done_i = 1'b0;
            if (!rstn) begin
                cnt0 = 0;
                cnt1 = 0;
            end else begin
                if (cnt0 > 0) begin
                    cnt0--;
                    if (cnt0 == 0) stg0_done_i = 1'b1;
                end
                if (cnt1 > 0) begin
                    cnt1--;
                    if (cnt1 == 0) stg1_done_i = 1'b1;
                end
                if (stg0_start_o) cnt0 = d0_lat;
                if (stg1_start_o) cnt1 = d1_lat;
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (stg0_done_i || stg1_done_i) last_done = cyc;
            if (stg0_start_o) begin
                s0_cnt++;
                if (exp0_q.size() == 0) check("stg0_unexpected_start", 1, 0);
                else check("stg0_idx", 32'(stg0_idx_o), 32'(exp0_q.pop_front()));
            end
            if (stg1_start_o) begin
                s1_cnt++;
                if (exp1_q.size() == 0) check("stg1_unexpected_start", 1, 0);
                else check("stg1_idx", 32'(stg1_idx_o), 32'(exp1_q.pop_front()));
            end
            if ((stg0_start_o || stg1_start_o) && have_rot)
                check("start_after_rot_latency", cyc, last_rot + 1);
            if (rotate_o) begin
                rot_cnt++;
                check("rot_after_done_latency", cyc, last_done + 1);
                last_rot = cyc;
                have_rot = 1'b1;
            end
            if (frame_done_o) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counts();
        s0_cnt = 0; s1_cnt = 0; rot_cnt = 0; fd_cnt = 0;
        have_rot = 1'b0;
        fd_cyc = -1;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        frame_start_i = 1'b1;
        ctu_num_i = W'(n);
        fs_cyc = cyc;
        @(negedge clk);
        frame_start_i = 1'b0;
        ctu_num_i = '0;
    endtask

    task automatic run_frame(input int n, input int d0, input int d1,
                             input int e_s0, input int e_s1, input int e_rot,
                             input logic e_sel);
        bit done;
        clear_counts();
        d0_lat = d0;
        d1_lat = d1;
        for (int i = 0; i < n; i++) begin
            exp0_q.push_back(W'(i));
            exp1_q.push_back(W'(i));
        end
        pulse_start(n);
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            #1;
            if (fd_cnt > 0) done = 1'b1;
        end
        if (!done) check("frame_done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        #1;
        check("stg0_start_count", s0_cnt, e_s0);
        check("stg1_start_count", s1_cnt, e_s1);
        check("rotate_count", rot_cnt, e_rot);
        check("frame_done_count", fd_cnt, 1);
        check("rot_sel_end", 32'(rot_sel_o), 32'(e_sel));
        check("busy_after_frame", 32'(busy_o), 0);
        check("exp_queues_drained", exp0_q.size() + exp1_q.size(), 0);
        if (n == 0) check("empty_frame_done_latency", fd_cyc, fs_cyc + 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stg0_start"}, 32'(stg0_start_o), 0);
        check({tag, "_stg0_idx"},   32'(stg0_idx_o), 0);
        check({tag, "_stg1_start"}, 32'(stg1_start_o), 0);
        check({tag, "_stg1_idx"},   32'(stg1_idx_o), 0);
        check({tag, "_rotate"},     32'(rotate_o), 0);
        check({tag, "_rot_sel"},    32'(rot_sel_o), 0);
        check({tag, "_busy"},       32'(busy_o), 0);
        check({tag, "_frame_done"}, 32'(frame_done_o), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   n;
        int   d0;
        int   d1;
        int   e_s0;
        int   e_s1;
        int   e_rot;
        logic e_sel;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // rot_sel carries over between frames; e_sel is cumulative from 0.
        vecs[0] = '{n: 3,  d0: 5,  d1: 5, e_s0: 3,  e_s1: 3,  e_rot: 4,  e_sel: 1'b0};
        vecs[1] = '{n: 3,  d0: 15, d1: 5, e_s0: 3,  e_s1: 3,  e_rot: 4,  e_sel: 1'b0};
        vecs[2] = '{n: 2,  d0: 3,  d1: 1, e_s0: 2,  e_s1: 2,  e_rot: 3,  e_sel: 1'b1};
        vecs[3] = '{n: 0,  d0: 1,  d1: 1, e_s0: 0,  e_s1: 0,  e_rot: 0,  e_sel: 1'b1};
        vecs[4] = '{n: 1,  d0: 2,  d1: 7, e_s0: 1,  e_s1: 1,  e_rot: 2,  e_sel: 1'b1};
        vecs[5] = '{n: 15, d0: 1,  d1: 2, e_s0: 15, e_s1: 15, e_rot: 16, e_sel: 1'b1};
        vecs[6] = '{n: 4,  d0: 4,  d1: 4, e_s0: 4,  e_s1: 4,  e_rot: 5,  e_sel: 1'b0};

        rstn = 1'b0;
        frame_start_i = 1'b0;
        ctu_num_i = '0;
        clear_counts();
        last_done = 0;
        last_rot = 0;
        fs_cyc = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].n, vecs[v].d0, vecs[v].d1, vecs[v].e_s0,
                      vecs[v].e_s1, vecs[v].e_rot, vecs[v].e_sel);
        end

        // Frame start with a different count pulsed in the middle of an N=2 frame.
        fork
            run_frame(2, 6, 6, 2, 2, 3, 1'b1);
            begin
                repeat (10) @(negedge clk);
                frame_start_i = 1'b1;
                ctu_num_i = W'(7);
                @(negedge clk);
                frame_start_i = 1'b0;
                ctu_num_i = '0;
            end
        join

        // Reset dropped during WAIT of slot 1.
        begin
            bit seen;
            clear_counts();
            d0_lat = 20;
            d1_lat = 20;
            exp0_q.push_back(W'(0));
            exp0_q.push_back(W'(1));
            exp1_q.push_back(W'(0));
            pulse_start(2);
            seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                #1;
                if (s0_cnt == 2) seen = 1'b1;
            end
            if (!seen) check("slot1_start_timeout", 0, 1);
            repeat (3) @(negedge clk);
            check("busy_before_reset", 32'(busy_o), 1);
            #3;
            rstn = 1'b0;
            #1;
            check_all_zero("midframe_reset");
            exp0_q.delete();
            exp1_q.delete();
            repeat (3) @(negedge clk);
            check("no_frame_done_after_reset", fd_cnt, 0);
            rstn = 1'b1;
            repeat (2) @(negedge clk);
            run_frame(1, 3, 3, 1, 1, 2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_rec_rot_ctrl

// File: doc/rec_rot_ctrl.md
REC_ROT_CTRL -- requirements
Module: rec_rot_ctrl

Interface
REQ-001 Parameter CTU_W, default 12, width of the CTU count and CTU index.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 frame_start_i  input  1  one-cycle pulse that starts a frame; honoured only in IDLE.
REQ-005 ctu_num_i  input  CTU_W  number of CTUs in the frame; sampled with frame_start_i.
REQ-006 stg0_start_o  output  1  one-cycle start pulse to the reconstruction stage, which writes buffer port 0.
REQ-007 stg0_idx_o  output  CTU_W  CTU index for stage 0; valid while stg0_start_o is high.
REQ-008 stg0_done_i  input  1  one-cycle done pulse from stage 0.
REQ-009 stg1_start_o  output  1  one-cycle start pulse to the consumer stage, which reads/writes buffer port 1.
REQ-010 stg1_idx_o  output  CTU_W  CTU index for stage 1; valid while stg1_start_o is high.
REQ-011 stg1_done_i  input  1  one-cycle done pulse from stage 1.
REQ-012 rotate_o  output  1  one-cycle pulse; drives rotate_i of the two-buffer rec rotator.
REQ-013 rot_sel_o  output  1  mirror of the rotator's buffer select; toggles on every rotate_o.
REQ-014 busy_o  output  1  high whenever state is not IDLE.
REQ-015 frame_done_o  output  1  one-cycle pulse when the frame finishes.

Function
REQ-016 FSM states: IDLE, START, WAIT, ROT, DONE.
REQ-017 IDLE: on frame_start_i, latch ctu_num_i into num_r and clear slot to 0. Next state is DONE if ctu_num_i==0, else START.
REQ-018 A frame runs N+1 slots (slot 0..N, where N=num_r). Stage 0 is active when slot<N. Stage 1 is active when slot>=1.
REQ-019 START lasts exactly one cycle:
- stg0_start_o = stage-0 active; stg0_idx_o = slot.
- stg1_start_o = stage-1 active; stg1_idx_o = slot-1.
- pend0/pend1 are set to the active flags.
- Next state is WAIT.
REQ-020 WAIT: a stgX_done_i pulse clears pendX. When both pend flags are 0 after the update, the next state is ROT. Dones arriving in the same cycle or in either order are both accepted.
REQ-021 Outside WAIT, or for a stage that is not pending, done pulses are ignored.
REQ-022 ROT lasts one cycle:
- rotate_o=1; rot_sel_o toggles.
- slot increments.
- Next state is DONE if the pre-increment slot == N, else START.
REQ-023 Latency: a final done in cycle t gives rotate_o in t+1 and the next start pulses in t+2.
REQ-024 DONE lasts one cycle: frame_done_o=1, then IDLE.
REQ-025 frame_start_i while busy_o=1 is ignored and has no effect on num_r or slot.
REQ-026 slot and num_r are CTU_W+1 bits wide so that slot==N with N=2^CTU_W-1 does not wrap. Index outputs are the low CTU_W bits.
REQ-027 A frame with ctu_num_i==0 produces no starts and no rotates; frame_done_o is asserted one cycle after frame_start_i.
REQ-028 Per frame of N>=1 CTUs: exactly N stage-0 starts, N stage-1 starts, and N+1 rotate_o pulses.
REQ-029 All outputs are registered or decoded from state/registers only. No combinational path exists from any input to any output.

Reset
REQ-030 rstn low asynchronously forces:
- state to IDLE;
- pend0, pend1, slot, num_r to 0;
- rot_sel_o and every output to 0.
REQ-031 Reset mid-frame abandons the frame; no frame_done_o is issued. rot_sel_o returns to 0, which is consistent with the rotator's own reset.

Structure
REQ-032 The shared enc_defines package holds the CTU_W default. The FSM state encoding is 3-bit binary localparams local to the module.
REQ-033 The block has no sub-module. It is a single FSM plus slot counter and pending flags.

Verification
REQ-034 N=3; each stage returns done 5 cycles after its start:
- stg0_idx sequence 0,1,2; stg1_idx sequence 0,1,2;
- 4 rotate_o pulses; rot_sel_o ends at 0;
- one frame_done_o.
REQ-035 Slot 2, stg1_done_i 10 cycles before stg0_done_i: rotate_o appears exactly 1 cycle after stg0_done_i.
REQ-036 Both dones in the same cycle t: rotate_o at t+1, next starts at t+2.
REQ-037 ctu_num_i=0: frame_done_o one cycle after frame_start_i; no start or rotate pulses.
REQ-038 frame_start_i with ctu_num_i=7 pulsed mid-frame: ignored; the original N=2 frame completes with 3 rotates.
REQ-039 rstn dropped during WAIT of slot 1:
- all outputs 0 immediately;
- a new frame with N=1 then runs 2 slots correctly, starting from rot_sel_o=0.
